pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline. Drives the write-enable and flush of the PC, the IF/ID register
//  and the ID/EX register. Resolves load-use hazards with a multi-cycle stall FSM, taken branches and jumps with
//  bubble insertion, and data-memory wait with a global freeze. Sits beside IF/ID; all outputs are same-cycle.
// PARAMETERS
//  LU_STALL_CYCLES  1   bubbles per load-use hazard (1 = MEM->EX forwarding present, 2 = none); legal 1..3
//  CNT_W            32  width of the statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk              in   1   pipeline clock; all state updates on posedge
//  reset            in   1   asynchronous, active-high reset
//  id_inst          in   32  instruction held in IF/ID (rs=[25:21], rt=[20:16], op=[31:26])
//  ex_mem_read      in   1   instruction in ID/EX is a load
//  ex_rt            in   5   destination register of the ID/EX load
//  ex_branch_taken  in   1   branch in EX resolved taken this cycle
//  id_jump          in   2   jump class decoded in ID (00 none, 01 j/jal, 10 jr)
//  mem_busy         in   1   data memory not ready; whole pipeline must hold
//  pc_we            out  1   PC write enable
//  ifid_we          out  1   IF/ID write enable
//  ifid_flush       out  1   IF/ID loads a bubble (inst=0) at next edge
//  idex_flush       out  1   ID/EX loads a bubble (all control = 0) at next edge
//  stall_busy       out  1   FSM is in STALL (a multi-cycle load-use stall is in progress)
// BEHAVIOUR
//  - Reset: state=RUN, stall counter=0; while reset is high: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=0,
//    stall_busy=0.
//  - lu_hit = ex_mem_read & ex_rt!=0 & (ex_rt==rs | (ex_rt==rt & uses_rt)).
//    uses_rt is true for op 0x00, 0x04, 0x05 and 0x2b.
//  - Default (no event): pc_we=1, ifid_we=1, both flushes 0.
//  - Priority per cycle: mem_busy > ex_branch_taken > load-use (lu_hit, or state STALL) > id_jump.
//  - mem_busy=1: pc_we=ifid_we=0, no flushes; FSM state and counter hold unchanged.
//  - ex_branch_taken: pc_we=1, ifid_flush=1, idex_flush=1. Aborts any stall: next state=RUN, counter=0.
//  - Load-use in RUN with lu_hit: pc_we=0, ifid_we=0, idex_flush=1.
//      LU_STALL_CYCLES==1 -> stay RUN.
//      else -> STALL with counter=LU_STALL_CYCLES-1.
//  - STALL: same outputs as a load-use stall, independent of lu_hit (the load has moved on). Counter decrements
//    each non-frozen cycle; at counter==1 the next state is RUN. stall_busy=1 throughout.
//  - id_jump!=0 with no higher-priority event: pc_we=1, ifid_flush=1, idex_flush=0. Exactly one bubble.
//  - A jr waiting on a load stalls first; its flush occurs on the first cycle after the stall ends.
//  - Total stall per hazard is exactly LU_STALL_CYCLES cycles, plus any mem_busy cycles.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//    - adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
//    - stall_cnt counts cycles with idex_flush & ~ifid_flush.
//    - flush_cnt counts cycles with ifid_flush.
//    - both saturate at all-ones and are cleared to 0 by reset.
//  HAZARD_STATS_EN undefined: the counters and their ports do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package pipe_ctrl_pkg: opcode constants (OP_RTYPE 0x00, OP_BEQ 0x04, OP_BNE 0x05, OP_SW 0x2b, OP_LW 0x23),
//    JUMP_* encodings, and the state enum {RUN=1'b0, STALL=1'b1}.
//  - Sub-module hazard_lu_detect: combinational lu_hit from id_inst, ex_mem_read and ex_rt.
//  - Top level holds the FSM, the counter, the priority mux and the optional statistics.
// TESTING
//  1. lw $8 in EX, add using rs=$8 in ID, LU_STALL_CYCLES=2
//     -> pc_we=0, idex_flush=1 for exactly 2 cycles, stall_busy=1 in the 2nd; then pc_we=1.
//  2. lw with ex_rt=0 and rs=0
//     -> no stall, pc_we=1.
//  3. ex_branch_taken=1 on the 2nd cycle of a STALL
//     -> ifid_flush=idex_flush=1, pc_we=1; next cycle state=RUN, stall_busy=0.
//  4. mem_busy=1 for 3 cycles in the middle of a STALL
//     -> all enables 0 during the busy cycles; counter holds; the stall finishes after busy drops.
//  5. id_jump=10 (jr $8) with lw $8 in EX
//     -> stall first; jump flush on the first cycle after the stall ends.
//  6. reset asserted mid-STALL
//     -> all outputs 0 immediately, state=RUN.
//     With HAZARD_STATS_EN: stall_cnt=0 after reset; incrementing to 2 after scenario 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode, jump-class and FSM state definitions shared by the hazard controller.
package pipe_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side signals of the hazard controller.
// HAZARD_STATS_EN adds the stall/flush statistics counters.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0] id_inst;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic [1:0]  id_jump;
    logic        mem_busy;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        stall_busy;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (output id_inst, ex_mem_read, ex_rt, ex_branch_taken, id_jump, mem_busy,
                    input pc_we, ifid_we, ifid_flush, idex_flush, stall_busy, stall_cnt, flush_cnt);
    modport slave  (input id_inst, ex_mem_read, ex_rt, ex_branch_taken, id_jump, mem_busy,
                    output pc_we, ifid_we, ifid_flush, idex_flush, stall_busy, stall_cnt, flush_cnt);
`else
    modport master (output id_inst, ex_mem_read, ex_rt, ex_branch_taken, id_jump, mem_busy,
                    input pc_we, ifid_we, ifid_flush, idex_flush, stall_busy);
    modport slave  (input id_inst, ex_mem_read, ex_rt, ex_branch_taken, id_jump, mem_busy,
                    output pc_we, ifid_we, ifid_flush, idex_flush, stall_busy);
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// hazard_lu_detect: flags an ID instruction that reads the register an EX-stage load is about to write.
module hazard_lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [15:0] inst_hi,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        lu_hit
);
    logic [5:0] op;
    logic [4:0] rs, rt;
    assign op = inst_hi[15:10];
    assign rs = inst_hi[9:5];
    assign rt = inst_hi[4:0];
    assign lu_hit = ex_mem_read && ex_rt != 5'd0 && (ex_rt == rs || (ex_rt == rt && uses_rt(op)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for PC, IF/ID and ID/EX; outputs are same-cycle.
// HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input logic clk,
    input logic reset,
    pipe_hazard_ctrl_if.slave bus
);
    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       lu_hit;
    logic       pc_we, ifid_we, ifid_flush, idex_flush;

    hazard_lu_detect u_lu (
        .inst_hi     (bus.id_inst[31:16]),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .lu_hit      (lu_hit)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    // Priority: memory freeze, then branch abort, then load-use, then jump bubble.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (bus.mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_n    = RUN;
            cnt_n      = 2'd0;
        end else if (state == STALL || lu_hit) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            if (state == STALL) begin
                cnt_n   = cnt - 2'd1;
                state_n = cnt == 2'd1 ? RUN : STALL;
            end else if (LU_STALL_CYCLES > 1) begin
                cnt_n   = 2'(LU_STALL_CYCLES - 1);
                state_n = STALL;
            end
        end else if (bus.id_jump != JUMP_NONE) begin
            ifid_flush = 1'b1;
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.ifid_we    = ifid_we;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.stall_busy = !reset && state == STALL;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_flush && !ifid_flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a remaining-bubble reference model.
module tb_pipe_hazard_ctrl;
    localparam int LU    = 2;
    localparam int CW    = 4;
    localparam int SATV  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rem = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(LU), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        logic [5:0] op;
        logic [4:0] rs, rt;
        op = bus.id_inst[31:26];
        rs = bus.id_inst[25:21];
        rt = bus.id_inst[20:16];
        return bus.ex_mem_read && bus.ex_rt != 0 &&
               (bus.ex_rt == rs || (bus.ex_rt == rt && (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b)));
    endfunction

    // Inputs are already applied shortly after a negedge; check, then advance one clock.
    task automatic cycle(input string tag);
        bit e_pc, e_ifwe, e_iff, e_idf, e_sb;
        int rem_n;
        rem_n = rem;
        e_pc = 1; e_ifwe = 1; e_iff = 0; e_idf = 0; e_sb = rem > 0;
        if (reset) begin
            e_pc = 0; e_ifwe = 0; e_sb = 0;
            rem_n = 0; m_stall = 0; m_flush = 0;
        end else if (bus.mem_busy) begin
            e_pc = 0; e_ifwe = 0;
        end else if (bus.ex_branch_taken) begin
            e_iff = 1; e_idf = 1; rem_n = 0;
        end else if (rem > 0 || model_hit()) begin
            e_pc = 0; e_ifwe = 0; e_idf = 1;
            rem_n = rem > 0 ? rem - 1 : LU - 1;
        end else if (bus.id_jump != 2'b00) begin
            e_iff = 1;
        end
        #1;
        chk({tag, ".pc_we"},      32'(bus.pc_we),      32'(e_pc));
        chk({tag, ".ifid_we"},    32'(bus.ifid_we),    32'(e_ifwe));
        chk({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'(e_iff));
        chk({tag, ".idex_flush"}, 32'(bus.idex_flush), 32'(e_idf));
        chk({tag, ".stall_busy"}, 32'(bus.stall_busy), 32'(e_sb));
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
        chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
`endif
        @(posedge clk);
        if (!reset) begin
            rem = rem_n;
            if (e_idf && !e_iff && m_stall < SATV) m_stall++;
            if (e_iff && m_flush < SATV) m_flush++;
        end else begin
            rem = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_mem_read = 0; bus.ex_rt = 0; bus.ex_branch_taken = 0;
        bus.id_jump = 0; bus.mem_busy = 0; bus.id_inst = 32'h0000_0020;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(6))
            0: return 6'h00;
            1: return 6'h04;
            2: return 6'h05;
            3: return 6'h2b;
            4: return 6'h23;
            5: return 6'h08;
            default: return 6'($urandom);
        endcase
    endfunction

    localparam logic [31:0] ADD_R8 = {6'h00, 5'd8, 5'd9, 5'd10, 11'h020};
    localparam logic [31:0] ADD_R0 = {6'h00, 5'd0, 5'd9, 5'd10, 11'h020};
    localparam logic [31:0] JR_R8  = {6'h00, 5'd8, 5'd0, 5'd0, 5'd0, 6'h08};

    initial begin
        reset = 1;
        idle();
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        reset = 0;
        cycle("idle");

        // Load-use with two bubbles: load moves on after the first stall cycle.
        bus.id_inst = ADD_R8; bus.ex_mem_read = 1; bus.ex_rt = 8;
        cycle("lu.s1");
        bus.ex_mem_read = 0; bus.ex_rt = 0;
        cycle("lu.s2");
        cycle("lu.after");
        chk("lu.rem", 32'(rem), 0);

        bus.id_inst = ADD_R0; bus.ex_mem_read = 1; bus.ex_rt = 0;
        cycle("r0.nostall");
        idle();

        // Branch resolves on the second stall cycle.
        bus.id_inst = ADD_R8; bus.ex_mem_read = 1; bus.ex_rt = 8;
        cycle("br.s1");
        bus.ex_mem_read = 0; bus.ex_branch_taken = 1;
        cycle("br.taken");
        idle();
        cycle("br.after");

        // Memory freeze in the middle of a stall.
        bus.id_inst = ADD_R8; bus.ex_mem_read = 1; bus.ex_rt = 8;
        cycle("mb.s1");
        bus.ex_mem_read = 0; bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) cycle("mb.busy");
        bus.mem_busy = 0;
        cycle("mb.s2");
        cycle("mb.after");

        // jr on a freshly loaded register: stall, then one jump bubble.
        bus.id_inst = JR_R8; bus.id_jump = 2'b10; bus.ex_mem_read = 1; bus.ex_rt = 8;
        cycle("jr.s1");
        bus.ex_mem_read = 0; bus.ex_rt = 0;
        cycle("jr.s2");
        cycle("jr.flush");
        idle();
        cycle("jr.after");

        // Reset while in STALL.
        bus.id_inst = ADD_R8; bus.ex_mem_read = 1; bus.ex_rt = 8;
        cycle("rs.s1");
        bus.ex_mem_read = 0; reset = 1;
        cycle("rs.reset");
        reset = 0;
        cycle("rs.after");

        for (int i = 0; i < 600; i++) begin
            bus.id_inst         = {pick_op(), pick_reg(), pick_reg(), 16'($urandom)};
            bus.ex_mem_read     = $urandom_range(2) != 0;
            bus.ex_rt           = pick_reg();
            bus.ex_branch_taken = $urandom_range(7) == 0;
            bus.id_jump         = 2'($urandom_range(5) < 2 ? $urandom_range(2) : 0);
            bus.mem_busy        = $urandom_range(6) == 0;
            reset               = $urandom_range(60) == 0;
            cycle("rand");
        end
        reset = 0;
        idle();
        cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
